// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end definitions: data width, fetch FSM encoding and the NOP word
// that the fetch stage presents while it holds no instruction.
package rv32i_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_addr_check.sv
// Combinational legality check for a fetch byte address: it must be word aligned and
// must fall inside the instruction memory.
module fetch_addr_check
  import rv32i_pkg::*;
#(
  parameter int IMEM_WORDS = 64
) (
  input  logic [XLEN-1:0] addr,
  output logic            illegal
);

  localparam logic [XLEN-3:0] WORD_LIMIT = (XLEN-2)'(IMEM_WORDS);

  assign illegal = (addr[1:0] != 2'b00) || (addr[XLEN-1:2] >= WORD_LIMIT);

endmodule

// File: rtl/fetch_unit.sv
// PC generation and instruction fetch: drives imem_addr, registers the returned word
// toward decode, handles stall, redirect/flush and illegal-address faults.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int          IMEM_WORDS   = 64
) (
  input  logic              clk,
  input  logic              reset,
  output logic [XLEN-1:0]   imem_addr,
  input  logic [XLEN-1:0]   imem_rd,
  input  logic              redirect,
  input  logic [XLEN-1:0]   redirect_target,
  input  logic              if_ready,
  output logic              if_valid,
  output logic [XLEN-1:0]   if_instr,
  output logic [XLEN-1:0]   if_pc,
  output logic [XLEN-1:0]   if_pc_plus4,
  output logic              fault,
  output logic [XLEN-1:0]   fault_pc,
  input  logic              fault_clear,
  output fetch_state_e      dbg_state
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_count,
  output logic [15:0]       flush_count
`endif
);

  // Handshake: an entry transfers to decode on every edge where if_valid && if_ready;
  // once if_valid is high the entry stays stable until that transfer (or a flush).

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_d;
  logic [XLEN-1:0] instr_d, ifpc_d, plus4_d, fault_pc_d;
  logic            fault_d;

  logic [XLEN-1:0] pc_inc;
  logic            pc_carry;
  logic            inc_range_bad, inc_illegal, target_illegal;
  logic            stall, handshake;

  assign {pc_carry, pc_inc} = {1'b0, pc_q} + 33'd4;
  assign inc_illegal        = inc_range_bad || pc_carry;
  assign stall              = if_valid && !if_ready;
  assign handshake          = if_valid && if_ready;
  assign imem_addr          = pc_q;
  assign dbg_state          = state_q;

  fetch_addr_check #(.IMEM_WORDS(IMEM_WORDS)) u_chk_target (
    .addr    (redirect_target),
    .illegal (target_illegal)
  );

  fetch_addr_check #(.IMEM_WORDS(IMEM_WORDS)) u_chk_inc (
    .addr    (pc_inc),
    .illegal (inc_range_bad)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    valid_d    = if_valid;
    instr_d    = if_instr;
    ifpc_d     = if_pc;
    plus4_d    = if_pc_plus4;
    fault_d    = fault;
    fault_pc_d = fault_pc;
    case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        if (redirect) begin
          // Flush; a handshake in this same cycle has already completed for decode.
          valid_d = 1'b0;
          if (target_illegal) begin
            fault_d    = 1'b1;
            fault_pc_d = redirect_target;
            state_d    = FAULT;
          end else begin
            pc_d = redirect_target;
          end
        end else if (!stall) begin
          instr_d = imem_rd;
          ifpc_d  = pc_q;
          plus4_d = pc_inc;
          valid_d = 1'b1;
          if (inc_illegal) begin
            fault_d    = 1'b1;
            fault_pc_d = pc_inc;
            state_d    = FAULT;
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      FAULT: begin
        if (handshake) valid_d = 1'b0;
        if (fault_clear) begin
          pc_d    = TRAP_VECTOR;
          fault_d = 1'b0;
          state_d = FETCH;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= BOOT;
      pc_q        <= RESET_VECTOR;
      if_valid    <= 1'b0;
      if_instr    <= NOP;
      if_pc       <= '0;
      if_pc_plus4 <= '0;
      fault       <= 1'b0;
      fault_pc    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      if_valid    <= valid_d;
      if_instr    <= instr_d;
      if_pc       <= ifpc_d;
      if_pc_plus4 <= plus4_d;
      fault       <= fault_d;
      fault_pc    <= fault_pc_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count <= '0;
      flush_count <= '0;
    end else begin
      if (handshake) fetch_count <= fetch_count + 32'd1;
      if (state_q == FETCH && redirect && flush_count != 16'hFFFF)
        flush_count <= flush_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by a randomized run
// scored against a transaction-level model of the delivered instruction stream.
module tb_fetch_unit;
  import rv32i_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr, imem_rd;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        if_ready, if_valid;
  logic [31:0] if_instr, if_pc, if_pc_plus4;
  logic        fault;
  logic [31:0] fault_pc;
  logic        fault_clear;
  fetch_state_e dbg_state;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [15:0] flush_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Instruction memory image: word N holds 0x1000_0000 + N.
  assign imem_rd = 32'h1000_0000 + {2'b00, imem_addr[31:2]};

  fetch_unit #(
    .RESET_VECTOR (32'h0000_0000),
    .TRAP_VECTOR  (32'h0000_0100),
    .IMEM_WORDS   (64)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_addr       (imem_addr),
    .imem_rd         (imem_rd),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .if_ready        (if_ready),
    .if_valid        (if_valid),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .if_pc_plus4     (if_pc_plus4),
    .fault           (fault),
    .fault_pc        (fault_pc),
    .fault_clear     (fault_clear),
    .dbg_state       (dbg_state)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count     (fetch_count),
    .flush_count     (flush_count)
`endif
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string name);
    n_checks++;
    if ({if_valid, if_instr, if_pc, if_pc_plus4, fault, fault_pc, imem_addr, dbg_state} !==
        {1'b0, NOP, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, BOOT}) begin
      n_fail++;
      $display("FAIL %s: valid=%0b instr=%h pc=%h pc4=%h fault=%0b fpc=%h addr=%h st=%0d, expected 0/%h/0/0/0/0/0/BOOT",
               name, if_valid, if_instr, if_pc, if_pc_plus4, fault, fault_pc, imem_addr, dbg_state, NOP);
    end
`ifdef FETCH_PERF_CNT_EN
    n_checks++;
    if (fetch_count !== 32'h0 || flush_count !== 16'h0) begin
      n_fail++;
      $display("FAIL %s_counters: fetch=%0d flush=%0d, expected 0/0", name, fetch_count, flush_count);
    end
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1; redirect = 1'b0; redirect_target = '0; if_ready = 1'b0; fault_clear = 1'b0;
    @(negedge clk);
    step();
    check_reset_values("reset");
  endtask

  task automatic test_sequential();
    reset = 1'b0; if_ready = 1'b1;
    step();
    n_checks++;
    if (if_valid !== 1'b0 || dbg_state !== FETCH || imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL boot_bubble: valid=%0b st=%0d addr=%h, expected 0/FETCH/0", if_valid, dbg_state, imem_addr);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++;
      if ({if_valid, if_pc, if_instr, if_pc_plus4} !==
          {1'b1, 32'(k*4), 32'h1000_0000 + 32'(k), 32'(k*4+4)}) begin
        n_fail++;
        $display("FAIL seq_%0d: valid=%0b pc=%h instr=%h pc4=%h, expected 1/%h/%h/%h", k,
                 if_valid, if_pc, if_instr, if_pc_plus4, 32'(k*4), 32'h1000_0000 + 32'(k), 32'(k*4+4));
      end
    end
  endtask

  task automatic test_stall();
    if_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++;
      if ({if_valid, if_instr, if_pc, imem_addr} !== {1'b1, 32'h1000_0002, 32'h8, 32'hC}) begin
        n_fail++;
        $display("FAIL stall_%0d: valid=%0b instr=%h pc=%h addr=%h, expected 1/10000002/8/c",
                 k, if_valid, if_instr, if_pc, imem_addr);
      end
    end
    if_ready = 1'b1;
    step();
    n_checks++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 32'hC, 32'h1000_0003}) begin
      n_fail++;
      $display("FAIL stall_release: valid=%0b pc=%h instr=%h, expected 1/c/10000003", if_valid, if_pc, if_instr);
    end
  endtask

  task automatic test_redirect();
    redirect = 1'b1; redirect_target = 32'h40;
    step();
    redirect = 1'b0;
    n_checks++;
    if (if_valid !== 1'b0 || imem_addr !== 32'h40) begin
      n_fail++;
      $display("FAIL redirect_bubble: valid=%0b addr=%h, expected 0/40", if_valid, imem_addr);
    end
    step();
    n_checks++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h40, 32'h1000_0010}) begin
      n_fail++;
      $display("FAIL redirect_target: valid=%0b pc=%h instr=%h, expected 1/40/10000010", if_valid, if_pc, if_instr);
    end
  endtask

  task automatic test_fault_redirect();
    redirect = 1'b1; redirect_target = 32'h42;
    step();
    n_checks++;
    if ({fault, fault_pc, if_valid, imem_addr, dbg_state} !== {1'b1, 32'h42, 1'b0, 32'h44, FAULT}) begin
      n_fail++;
      $display("FAIL misaligned_target: fault=%0b fpc=%h valid=%0b addr=%h st=%0d, expected 1/42/0/44/FAULT",
               fault, fault_pc, if_valid, imem_addr, dbg_state);
    end
    redirect_target = 32'h20;
    step();
    step();
    redirect = 1'b0;
    n_checks++;
    if ({fault, if_valid, imem_addr} !== {1'b1, 1'b0, 32'h44}) begin
      n_fail++;
      $display("FAIL fault_halt: fault=%0b valid=%0b addr=%h, expected 1/0/44", fault, if_valid, imem_addr);
    end
    fault_clear = 1'b1;
    step();
    fault_clear = 1'b0;
    n_checks++;
    if ({fault, fault_pc, imem_addr, dbg_state} !== {1'b0, 32'h42, 32'h100, FETCH}) begin
      n_fail++;
      $display("FAIL fault_clear: fault=%0b fpc=%h addr=%h st=%0d, expected 0/42/100/FETCH",
               fault, fault_pc, imem_addr, dbg_state);
    end
  endtask

  task automatic test_end_of_mem();
    redirect = 1'b1; redirect_target = 32'hF0; if_ready = 1'b1;
    step();
    redirect = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      n_checks++;
      if ({if_valid, if_pc, if_instr} !== {1'b1, 32'hF0 + 32'(k*4), 32'h1000_003C + 32'(k)}) begin
        n_fail++;
        $display("FAIL eom_word_%0d: valid=%0b pc=%h instr=%h", k, if_valid, if_pc, if_instr);
      end
    end
    n_checks++;
    if ({fault, fault_pc, dbg_state, imem_addr} !== {1'b1, 32'h100, FAULT, 32'hFC}) begin
      n_fail++;
      $display("FAIL eom_fault: fault=%0b fpc=%h st=%0d addr=%h, expected 1/100/FAULT/fc",
               fault, fault_pc, dbg_state, imem_addr);
    end
    if_ready = 1'b0;
    step();
    n_checks++;
    if ({if_valid, if_pc} !== {1'b1, 32'hFC}) begin
      n_fail++;
      $display("FAIL eom_hold: valid=%0b pc=%h, expected 1/fc", if_valid, if_pc);
    end
    if_ready = 1'b1;
    step();
    n_checks++;
    if ({if_valid, fault, imem_addr} !== {1'b0, 1'b1, 32'hFC}) begin
      n_fail++;
      $display("FAIL eom_drain: valid=%0b fault=%0b addr=%h, expected 0/1/fc", if_valid, fault, imem_addr);
    end
  endtask

  task automatic test_reset_in_fault();
    reset = 1'b1;
    step();
    check_reset_values("reset_in_fault");
    reset = 1'b0;
  endtask

  task automatic test_reset_in_stall();
    if_ready = 1'b0;
    step();
    step();
    step();
    n_checks++;
    if ({if_valid, if_pc, imem_addr} !== {1'b1, 32'h0, 32'h4}) begin
      n_fail++;
      $display("FAIL pre_reset_stall: valid=%0b pc=%h addr=%h, expected 1/0/4", if_valid, if_pc, imem_addr);
    end
    reset = 1'b1;
    step();
    check_reset_values("reset_in_stall");
    reset = 1'b0;
  endtask

  // Model: decode must see consecutive word addresses, restarting at each redirect
  // target; every accepted word carries its memory image value.
  task automatic test_random();
    logic [31:0] exp_next;
    int hs = 0;
    int redirs = 0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    exp_next = 32'h0;
    for (int i = 0; i < 1500; i++) begin
      if_ready = ($urandom_range(0, 3) != 0);
      redirect = ($urandom_range(0, 7) == 0) || (imem_addr >= 32'hC0);
      redirect_target = {22'h0, 8'($urandom_range(0, 47)), 2'b00};
      if (if_valid && if_ready) begin
        n_checks++;
        if ({if_pc, if_instr, if_pc_plus4} !== {exp_next, 32'h1000_0000 + (exp_next >> 2), exp_next + 32'd4}) begin
          n_fail++;
          $display("FAIL rand_stream cycle %0d: pc=%h instr=%h pc4=%h, expected pc=%h", i,
                   if_pc, if_instr, if_pc_plus4, exp_next);
        end
        exp_next = exp_next + 32'd4;
        hs++;
      end
      if (redirect) begin
        exp_next = redirect_target;
        redirs++;
      end
      if (fault !== 1'b0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rand_no_fault cycle %0d: fault=%0b fpc=%h, expected 0", i, fault, fault_pc);
      end
      step();
    end
    redirect = 1'b0;
    n_checks++;
    if (hs < 300) begin
      n_fail++;
      $display("FAIL rand_progress: handshakes=%0d, expected at least 300", hs);
    end
`ifdef FETCH_PERF_CNT_EN
    n_checks++;
    if (fetch_count !== 32'(hs) || flush_count !== 16'(redirs)) begin
      n_fail++;
      $display("FAIL perf_counters: fetch=%0d flush=%0d, expected %0d/%0d", fetch_count, flush_count, hs, redirs);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_fault_redirect();
    test_end_of_mem();
    test_reset_in_fault();
    test_reset_in_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
